// File: rtl/shift_ctrl.sv
// Command-driven controller for a packet head shifter: queues per-packet shift
// commands, pairs each one with a packet's start beat, and tags every accepted beat.
module shift_ctrl #(
    parameter int HS_W      = 4,
    parameter int MS_W      = 4,
    parameter int CMD_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [HS_W-1:0]  i_cmd_head_shift,
    input  logic [MS_W-1:0]  i_cmd_meta_shift,
    input  logic             i_beat_valid,
    input  logic             i_beat_start,
    input  logic             i_beat_tail,
    output logic             o_beat_ready,
    output logic             o_tag_valid,
    output logic             o_tag_start,
    output logic             o_tag_tail,
    output logic             o_tag_shift,
    output logic [HS_W-1:0]  o_head_shift,
    output logic [MS_W-1:0]  o_meta_shift,
    output logic [15:0]      o_pkt_cnt,
    output logic             o_err
);

    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CMD,
        IN_PKT
    } state_t;

    state_t r_state;

    logic [HS_W-1:0] r_head_mem [CMD_DEPTH];
    logic [MS_W-1:0] r_meta_mem [CMD_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_cmd_ready;

    logic            r_tag_valid;
    logic            r_tag_start;
    logic            r_tag_tail;
    logic            r_tag_shift;
    logic [HS_W-1:0] r_head_shift;
    logic [MS_W-1:0] r_meta_shift;
    logic [15:0]     r_pkt_cnt;
    logic            r_err;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_beat_ready;
    logic            w_accept;
    logic            w_start_acc;
    logic            w_start_shift;
    logic [CW-1:0]   w_count_next;
    logic [HS_W-1:0] w_fifo_head;
    logic [MS_W-1:0] w_fifo_meta;

    assign w_empty       = (r_count == '0);
    assign w_push        = i_cmd_valid && r_cmd_ready;
    assign w_fifo_head   = r_head_mem[r_rd_ptr];
    assign w_fifo_meta   = r_meta_mem[r_rd_ptr];
    assign w_start_shift = (w_fifo_head != '0) || (w_fifo_meta != '0);

    // A start beat is only accepted when a command is already queued, so every
    // accepted start pops exactly one command.
    always_comb begin
        w_beat_ready = 1'b0;
        if (!i_rst) begin
            case (r_state)
                IDLE, IN_PKT: w_beat_ready = !(i_beat_valid && i_beat_start && w_empty);
                WAIT_CMD:     w_beat_ready = !w_empty;
                default:      w_beat_ready = 1'b0;
            endcase
        end
    end

    assign w_accept     = i_beat_valid && w_beat_ready;
    assign w_start_acc  = w_accept && i_beat_start;
    assign w_pop        = w_start_acc;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_head_mem[r_wr_ptr] <= i_cmd_head_shift;
            r_meta_mem[r_wr_ptr] <= i_cmd_meta_shift;
        end
    end

    // Ready follows the post-edge occupancy, so a pop never frees a slot early.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_cmd_ready <= (w_count_next != FULL_CNT);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_tag_valid  <= 1'b0;
            r_tag_start  <= 1'b0;
            r_tag_tail   <= 1'b0;
            r_tag_shift  <= 1'b0;
            r_head_shift <= '0;
            r_meta_shift <= '0;
            r_pkt_cnt    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_tag_valid <= 1'b0;
            r_tag_start <= 1'b0;
            r_tag_tail  <= 1'b0;
            r_tag_shift <= 1'b0;
            if (w_start_acc) begin
                // A start inside an open packet abandons it uncounted.
                if (r_state == IN_PKT) begin
                    r_err <= 1'b1;
                end
                r_head_shift <= w_fifo_head;
                r_meta_shift <= w_fifo_meta;
                r_tag_valid  <= 1'b1;
                r_tag_start  <= 1'b1;
                r_tag_tail   <= i_beat_tail;
                r_tag_shift  <= w_start_shift;
                if (i_beat_tail) begin
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    r_state   <= IDLE;
                end else begin
                    r_state   <= IN_PKT;
                end
            end else if (w_accept && (r_state == IN_PKT)) begin
                r_tag_valid <= 1'b1;
                r_tag_tail  <= i_beat_tail;
                r_tag_shift <= (r_head_shift != '0) || (r_meta_shift != '0);
                if (i_beat_tail) begin
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    r_state   <= IDLE;
                end
            end else if (w_accept) begin
                r_err   <= 1'b1;
                r_state <= IDLE;
            end else if (i_beat_valid && i_beat_start) begin
                if (r_state == IN_PKT) begin
                    r_err <= 1'b1;
                end
                r_state <= WAIT_CMD;
            end else if (r_state == WAIT_CMD) begin
                r_state <= IDLE;
            end
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_beat_ready = w_beat_ready;
    assign o_tag_valid  = r_tag_valid;
    assign o_tag_start  = r_tag_start;
    assign o_tag_tail   = r_tag_tail;
    assign o_tag_shift  = r_tag_shift;
    assign o_head_shift = r_head_shift;
    assign o_meta_shift = r_meta_shift;
    assign o_pkt_cnt    = r_pkt_cnt;
    assign o_err        = r_err;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: command queueing, beat tagging, stalls,
// protocol errors and mid-packet reset, each against hand-computed values.
module tb_shift_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [3:0]  i_cmd_head_shift;
    logic [3:0]  i_cmd_meta_shift;
    logic        i_beat_valid;
    logic        i_beat_start;
    logic        i_beat_tail;
    logic        o_beat_ready;
    logic        o_tag_valid;
    logic        o_tag_start;
    logic        o_tag_tail;
    logic        o_tag_shift;
    logic [3:0]  o_head_shift;
    logic [3:0]  o_meta_shift;
    logic [15:0] o_pkt_cnt;
    logic        o_err;

    int nChecks;
    int nErrors;

    shift_ctrl #(.HS_W(4), .MS_W(4), .CMD_DEPTH(4)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_head_shift(i_cmd_head_shift),
        .i_cmd_meta_shift(i_cmd_meta_shift),
        .i_beat_valid(i_beat_valid),
        .i_beat_start(i_beat_start),
        .i_beat_tail(i_beat_tail),
        .o_beat_ready(o_beat_ready),
        .o_tag_valid(o_tag_valid),
        .o_tag_start(o_tag_start),
        .o_tag_tail(o_tag_tail),
        .o_tag_shift(o_tag_shift),
        .o_head_shift(o_head_shift),
        .o_meta_shift(o_meta_shift),
        .o_pkt_cnt(o_pkt_cnt),
        .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic start, input logic tail);
        i_beat_valid = valid;
        i_beat_start = start;
        i_beat_tail  = tail;
    endtask

    task automatic setCmd(input logic valid, input logic [3:0] head, input logic [3:0] meta);
        i_cmd_valid      = valid;
        i_cmd_head_shift = head;
        i_cmd_meta_shift = meta;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkTag(input string tag, input logic v, input logic s, input logic t, input logic sh);
        checkOutput({tag, "_valid"}, 32'(o_tag_valid), 32'(v));
        checkOutput({tag, "_start"}, 32'(o_tag_start), 32'(s));
        checkOutput({tag, "_tail"},  32'(o_tag_tail),  32'(t));
        checkOutput({tag, "_shift"}, 32'(o_tag_shift), 32'(sh));
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        i_rst   = 1'b0;
        setCmd(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        #2 i_rst = 1'b1;
        #1;
        checkOutput("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        checkOutput("rst_beat_ready", 32'(o_beat_ready), 32'd0);
        checkTag("rst_tag", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_head", 32'(o_head_shift), 32'd0);
        checkOutput("rst_meta", 32'(o_meta_shift), 32'd0);
        checkOutput("rst_cnt", 32'(o_pkt_cnt), 32'd0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        checkOutput("cmd_ready_after_rst", 32'(o_cmd_ready), 32'd1);

        // Three-beat packet with command (3,0)
        setCmd(1'b1, 4'd3, 4'd0);
        tick();
        setCmd(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1 checkOutput("s1_beat_ready", 32'(o_beat_ready), 32'd1);
        tick();
        checkTag("s1_b1", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("s1_head", 32'(o_head_shift), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkTag("s1_b2", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        checkTag("s1_b3", 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("s1_cnt", 32'(o_pkt_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkTag("s1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_head_hold", 32'(o_head_shift), 32'd3);

        // Single-beat packet with zero shift
        setCmd(1'b1, 4'd0, 4'd0);
        tick();
        setCmd(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkTag("s4_tag", 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_head", 32'(o_head_shift), 32'd0);
        checkOutput("s4_cnt", 32'(o_pkt_cnt), 32'd2);

        // Start beat on empty FIFO stalls until the cycle after the push
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1 checkOutput("s2_ready_empty", 32'(o_beat_ready), 32'd0);
        tick();
        checkOutput("s2_ready_wait1", 32'(o_beat_ready), 32'd0);
        checkOutput("s2_no_tag", 32'(o_tag_valid), 32'd0);
        tick();
        setCmd(1'b1, 4'd5, 4'd2);
        checkOutput("s2_ready_wait2", 32'(o_beat_ready), 32'd0);
        tick();
        setCmd(1'b0, 4'd0, 4'd0);
        checkOutput("s2_ready_after_push", 32'(o_beat_ready), 32'd1);
        tick();
        checkTag("s2_start", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("s2_head", 32'(o_head_shift), 32'd5);
        checkOutput("s2_meta", 32'(o_meta_shift), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkTag("s2_tail", 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("s2_cnt", 32'(o_pkt_cnt), 32'd3);

        // Fill the FIFO, hold a fifth command, then free one slot
        setCmd(1'b1, 4'd1, 4'd1);
        tick();
        setCmd(1'b1, 4'd2, 4'd0);
        tick();
        setCmd(1'b1, 4'd0, 4'd3);
        tick();
        setCmd(1'b1, 4'd4, 4'd4);
        tick();
        checkOutput("s3_full", 32'(o_cmd_ready), 32'd0);
        setCmd(1'b1, 4'd7, 4'd7);
        tick();
        tick();
        checkOutput("s3_held", 32'(o_cmd_ready), 32'd0);
        setCmd(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s3_ready_back", 32'(o_cmd_ready), 32'd1);
        checkOutput("s3_head", 32'(o_head_shift), 32'd1);
        checkOutput("s3_meta", 32'(o_meta_shift), 32'd1);
        checkOutput("s3_cnt", 32'(o_pkt_cnt), 32'd4);

        // Second start before tail: error, count unchanged, next command used
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("s5_head1", 32'(o_head_shift), 32'd2);
        checkOutput("s5_err0", 32'(o_err), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("s5_err1", 32'(o_err), 32'd1);
        checkOutput("s5_cnt_same", 32'(o_pkt_cnt), 32'd4);
        checkTag("s5_restart", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("s5_head2", 32'(o_head_shift), 32'd0);
        checkOutput("s5_meta2", 32'(o_meta_shift), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s5_cnt_tail", 32'(o_pkt_cnt), 32'd5);
        tick();
        checkOutput("s5_err_sticky", 32'(o_err), 32'd1);

        // Reset mid-packet with two commands queued
        setCmd(1'b1, 4'd6, 4'd1);
        tick();
        setCmd(1'b1, 4'd1, 4'd2);
        tick();
        setCmd(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("s6_head", 32'(o_head_shift), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        i_rst = 1'b1;
        #1;
        checkOutput("s6_cmd_ready", 32'(o_cmd_ready), 32'd0);
        checkOutput("s6_beat_ready", 32'(o_beat_ready), 32'd0);
        checkTag("s6_tag", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s6_head_rst", 32'(o_head_shift), 32'd0);
        checkOutput("s6_meta_rst", 32'(o_meta_shift), 32'd0);
        checkOutput("s6_cnt_rst", 32'(o_pkt_cnt), 32'd0);
        checkOutput("s6_err_rst", 32'(o_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        i_rst = 1'b0;
        tick();
        checkOutput("s6_cmd_ready_rel", 32'(o_cmd_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1 checkOutput("s6_fifo_empty", 32'(o_beat_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Push and pop in the same cycle keep occupancy at one
        setCmd(1'b1, 4'd3, 4'd3);
        tick();
        setCmd(1'b1, 4'd1, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        setCmd(1'b0, 4'd0, 4'd0);
        checkOutput("pp_head1", 32'(o_head_shift), 32'd3);
        #1 checkOutput("pp_ready_one_left", 32'(o_beat_ready), 32'd1);
        tick();
        checkOutput("pp_head2", 32'(o_head_shift), 32'd1);
        checkOutput("pp_cnt", 32'(o_pkt_cnt), 32'd2);
        #1 checkOutput("pp_now_empty", 32'(o_beat_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Non-start beat in IDLE is consumed with an error and no tag
        checkOutput("ns_err_before", 32'(o_err), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        #1 checkOutput("ns_beat_ready", 32'(o_beat_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ns_no_tag", 32'(o_tag_valid), 32'd0);
        checkOutput("ns_err", 32'(o_err), 32'd1);
        checkOutput("ns_cnt", 32'(o_pkt_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL take parameter HS_W, default 4: width of the head shift amount.
REQ-002 SHALL take parameter MS_W, default 4: width of the meta shift amount.
REQ-003 SHALL take parameter CMD_DEPTH, default 4 (power of 2): number of entries in the command FIFO.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_cmd_valid, input, 1: a per-packet shift command is offered.
REQ-007 SHALL have port o_cmd_ready, output, 1: the command FIFO can accept an entry.
REQ-008 SHALL have port i_cmd_head_shift, input, HS_W: head shift amount for one packet.
REQ-009 SHALL have port i_cmd_meta_shift, input, MS_W: meta shift amount for one packet.
REQ-010 SHALL have port i_beat_valid, input, 1: a packet beat is offered.
REQ-011 SHALL have port i_beat_start, input, 1: the offered beat is the first beat of a packet.
REQ-012 SHALL have port i_beat_tail, input, 1: the offered beat is the last beat of a packet.
REQ-013 SHALL have port o_beat_ready, output, 1: the offered beat is accepted this cycle.
REQ-014 SHALL have port o_tag_valid, output, 1: tag valid bit for the head shifter.
REQ-015 SHALL have port o_tag_start, output, 1: tag start bit for the head shifter.
REQ-016 SHALL have port o_tag_tail, output, 1: tag tail bit for the head shifter.
REQ-017 SHALL have port o_tag_shift, output, 1: tag shift bit for the head shifter.
REQ-018 SHALL have port o_head_shift, output, HS_W: head shift amount driven to the head shifter.
REQ-019 SHALL have port o_meta_shift, output, MS_W: meta shift amount driven to the head shifter.
REQ-020 SHALL have port o_pkt_cnt, output, 16: count of completed packets.
REQ-021 SHALL have port o_err, output, 1: sticky protocol-error flag.

Function
REQ-022 SHALL hold commands in a CMD_DEPTH-entry FIFO; a command is pushed when i_cmd_valid and o_cmd_ready are both high.
REQ-023 SHALL drive o_cmd_ready = FIFO not full, registered, with no bypass; a pop while full does not raise ready in the same cycle.
REQ-024 SHALL implement FSM states IDLE, WAIT_CMD and IN_PKT.
REQ-025 SHALL leave IDLE as follows when a start beat is valid: FIFO non-empty -> pop a command, latch both shift amounts, go to IN_PKT (or stay IDLE if tail is also set); FIFO empty -> go to WAIT_CMD.
REQ-026 SHALL, in WAIT_CMD, drive o_beat_ready = 0 and, on the first cycle the FIFO is non-empty, pop a command, accept the held start beat and proceed as in REQ-025; an empty-FIFO push never bypasses, so a stall is at least 1 cycle.
REQ-027 SHALL, in IN_PKT, accept every valid beat and return to IDLE on the tail beat.
REQ-028 SHALL drive o_beat_ready = 1 in IDLE and IN_PKT, except in IDLE when a start beat is offered and the FIFO is empty.
REQ-029 SHALL, for every accepted beat, assert o_tag_valid exactly 1 cycle later (latency 1, registered), with o_tag_start and o_tag_tail copied from the beat.
REQ-030 SHALL drive o_tag_shift = (latched head shift != 0) OR (latched meta shift != 0).
REQ-031 SHALL hold o_head_shift and o_meta_shift constant from the start tag through the tail tag, and keep them after the tail until the next start.
REQ-032 SHALL deassert o_tag_valid, o_tag_start, o_tag_tail and o_tag_shift in every cycle with no accepted beat.
REQ-033 SHALL treat a single-beat packet (start and tail set together) as a complete packet: one command popped, o_pkt_cnt incremented, FSM back in IDLE.
REQ-034 SHALL increment o_pkt_cnt by 1 on each accepted tail beat of a well-formed packet, wrapping from 0xFFFF to 0.
REQ-035 SHALL, on a start beat accepted in IN_PKT (missing tail), set o_err and treat the beat as a new start per REQ-025, without incrementing o_pkt_cnt.
REQ-036 SHALL, on a non-start beat valid in IDLE, set o_err and consume the beat with no tag output.
REQ-037 SHALL keep o_err set until reset.
REQ-038 SHALL allow a command push and pop in the same cycle, leaving occupancy unchanged.

Reset
REQ-039 SHALL, while i_rst is high, asynchronously force: FSM to IDLE, FIFO empty, o_cmd_ready = 0, o_beat_ready = 0, all tag outputs 0, o_head_shift = 0, o_meta_shift = 0, o_pkt_cnt = 0, o_err = 0.
REQ-040 SHALL raise o_cmd_ready on the first clock edge after i_rst is released.
REQ-041 SHALL discard any partial packet and all queued commands on reset asserted mid-packet.

Verification
REQ-042 SHALL be covered by this scenario: push cmd (head 3, meta 0), then a 3-beat packet -> tags valid 1 cycle after each beat; start=1 on beat 1, tail=1 on beat 3; shift=1; o_head_shift=3; o_pkt_cnt=1.
REQ-043 SHALL be covered by this scenario: start beat with FIFO empty, cmd pushed 2 cycles later -> o_beat_ready low until the cycle after the push; start tag then carries the new shift values.
REQ-044 SHALL be covered by this scenario: push 4 cmds with no beats -> o_cmd_ready=0; 5th cmd held; one single-beat packet -> o_cmd_ready returns to 1 on the next cycle.
REQ-045 SHALL be covered by this scenario: cmd (0,0) plus a single-beat packet -> one tag with start=tail=1, shift=0; o_pkt_cnt increments.
REQ-046 SHALL be covered by this scenario: second start beat before tail -> o_err=1 and stays 1; o_pkt_cnt unchanged; second packet uses the next command.
REQ-047 SHALL be covered by this scenario: i_rst pulsed mid-packet with 2 cmds queued -> all outputs 0 immediately; after release, FIFO empty and FSM in IDLE.
